flex_counter_updn: RTL and testbench
====================================

Name: flex_counter_updn

Overview:
- Parametrised successor to the team's flex counter.
- Adds up/down direction, synchronous parallel load, and a one-shot mode that holds at terminal count.
- Keeps the team's rollover convention: the counter wraps to 1, never to 0, so 0 only appears after reset or clear.
- Used as a generic timer/bit-counter wherever a block needs programmable-length count-up or countdown sequencing.

Parameters:
- NUM_CNT_BITS, 4, width of count_out, rollover_val and load_val (legal range 2..32).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous clear: count to 0, exit hold.
- count_enable  input  1  advance count one step this cycle.
- up_down  input  1  1 = count up, 0 = count down; sampled on each enabled cycle.
- one_shot  input  1  1 = hold at terminal count; 0 = wrap.
- load  input  1  synchronous load of load_val, exit hold.
- load_val  input  NUM_CNT_BITS  value written on load.
- rollover_val  input  NUM_CNT_BITS  upper bound of count range; 0 = counter disabled.
- count_out  output  NUM_CNT_BITS  registered count.
- rollover_flag  output  1  registered; high while count_out equals the current terminal value.
- done  output  1  registered; high while in HOLD state (one-shot complete).

Behaviour:
- Reset: synchronous, active-high. rst=1 at a clock edge sets count_out=0, rollover_flag=0, done=0, state=RUN, regardless of any other input. Reset mid-operation behaves identically.
- Priority per cycle: rst > clear > load > count_enable.
- clear: count_out=0, state=RUN, done=0, rollover_flag=0 next cycle.
- load: count_out=load_val, state=RUN, done=0. load_val > rollover_val is allowed and is stored as-is.
- Terminal value: rollover_val when up_down=1; 1 when up_down=0.
- Up step:
  - If count_out >= rollover_val, next count = 1 (wrap).
  - Otherwise next count = count_out+1.
  - The >= comparison covers rollover_val being lowered below the current count.
- Down step:
  - If count_out <= 1, next count = rollover_val (wrap; covers count 0 after reset/clear).
  - Otherwise next count = count_out-1.
- rollover_val == 0: count_enable is ignored, count holds, rollover_flag=0. clear and load still act.
- rollover_flag:
  - Registered from the next-state count, so it is high in the same cycle count_out equals terminal.
  - Recomputed every cycle against the current up_down and rollover_val, so a direction or bound change updates it one cycle later even without enable.
- State machine (2 states):
  - RUN: counts on enable. If one_shot=1 and the next count equals terminal, transition to HOLD at the same edge the terminal value is written.
  - HOLD: count_out frozen at terminal, done=1, count_enable ignored. Exit only via clear, load or rst. Deasserting one_shot does not release HOLD.
- one_shot=0: never enters HOLD; counts wrap continuously.
- Simultaneous events:
  - load with count_enable: load wins, no step applied.
  - clear with load: clear wins.
- Latency: one cycle from enabled edge to updated count_out, rollover_flag and done.
- All arithmetic is unsigned at NUM_CNT_BITS; no intermediate overflow is possible given the compare-before-step rules.

Decomposition:
- Package flex_cnt_pkg holds:
  - typedef enum logic {RUN, HOLD} flex_cnt_state_t
  - constants DIR_UP=1'b1, DIR_DOWN=1'b0
- One combinational sub-module, flex_cnt_next_val (parametrised by NUM_CNT_BITS). Inputs: count, up_down, rollover_val. Outputs: next count and is_terminal. The top holds the registers, priority muxing and the FSM.

Test Plan:
- Up wrap: NUM_CNT_BITS=4, rollover_val=5, up, enable continuously from reset.
  - Required count_out: 1,2,3,4,5,1,2.
  - Required rollover_flag: high only in cycles where count_out=5.
- Down wrap: rollover_val=3, down, from reset.
  - Required count_out: 3,2,1,3,2.
  - Required rollover_flag: high when count_out=1.
- One-shot: one_shot=1, up, rollover_val=4, 8 enabled cycles.
  - Required: count_out reaches 4 and stays; done=1 from that cycle onward.
  - Then load=1 with load_val=2: count_out=2, done=0 next cycle.
- Priority: at count 3, assert clear, load(load_val=7) and count_enable together → count_out=0. Then load with count_enable, load_val=7 → count_out=7, not 8.
- Bound change: count_out=9, rollover_val changed to 6, one up enable → count_out=1. Then rollover_val=0 with enable held 4 cycles → count_out stays 1, rollover_flag=0.
- Reset mid-HOLD: in HOLD with count 4, assert rst for one cycle alongside load=1 → count_out=0, done=0, rollover_flag=0. Counting resumes from 1 on the next enable.

Source files
------------

// File: rtl/flex_cnt_pkg.sv
// flex_cnt_pkg: shared state and direction definitions for the flex up/down counter
package flex_cnt_pkg;
  typedef enum logic {RUN, HOLD} flex_cnt_state_t;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
endpackage

// File: rtl/flex_cnt_next_val.sv
// flex_cnt_next_val: one up/down step with wrap-to-1 and terminal detection of the stepped value
module flex_cnt_next_val
  import flex_cnt_pkg::*;
#(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic [NUM_CNT_BITS-1:0] count,
  input  logic                    up_down,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] next_count,
  output logic                    is_terminal
);
  localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);
  always_comb begin
    next_count = (up_down == DIR_UP) ? ((count >= rollover_val) ? ONE : count + ONE)
                                     : ((count <= ONE) ? rollover_val : count - ONE);
    is_terminal = next_count == ((up_down == DIR_UP) ? rollover_val : ONE);
  end
endmodule

// File: rtl/flex_counter_updn.sv
// flex_counter_updn: programmable up/down counter with load, clear and one-shot hold at terminal
module flex_counter_updn
  import flex_cnt_pkg::*;
#(
  parameter int NUM_CNT_BITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic                    count_enable,
  input  logic                    up_down,
  input  logic                    one_shot,
  input  logic                    load,
  input  logic [NUM_CNT_BITS-1:0] load_val,
  input  logic [NUM_CNT_BITS-1:0] rollover_val,
  output logic [NUM_CNT_BITS-1:0] count_out,
  output logic                    rollover_flag,
  output logic                    done
);
  localparam logic [NUM_CNT_BITS-1:0] ONE = NUM_CNT_BITS'(1);
  flex_cnt_state_t state, state_d;
  logic [NUM_CNT_BITS-1:0] step_val, count_d, term_val;
  logic step_term, step_ok, flag_d;
  flex_cnt_next_val #(.NUM_CNT_BITS(NUM_CNT_BITS)) u_next (
    .count(count_out),
    .up_down(up_down),
    .rollover_val(rollover_val),
    .next_count(step_val),
    .is_terminal(step_term)
  );
  always_comb begin
    step_ok = count_enable && state == RUN && rollover_val != '0;
    count_d = clear ? '0 : load ? load_val : step_ok ? step_val : count_out;
    state_d = (clear || load) ? RUN : (step_ok && one_shot && step_term) ? HOLD : state;
    term_val = (up_down == DIR_UP) ? rollover_val : ONE;
    flag_d = !clear && rollover_val != '0 && count_d == term_val;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
      count_out <= '0;
      rollover_flag <= 1'b0;
    end else begin
      state <= state_d;
      count_out <= count_d;
      rollover_flag <= flag_d;
    end
  end
  assign done = state == HOLD;
endmodule

// File: tb/tb_flex_counter_updn.sv
// tb_flex_counter_updn: directed vector table plus one-shot and reset-in-hold sequences
module tb_flex_counter_updn;
  logic clk = 1'b0;
  logic rst, clear, count_enable, up_down, one_shot, load;
  logic [3:0] load_val, rollover_val, count_out;
  logic rollover_flag, done;
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic rst, clr, ld, en, ud, os;
    logic [3:0] lv, rv, ec;
    logic ef, ed;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  flex_counter_updn #(.NUM_CNT_BITS(4)) dut (
    .clk(clk), .rst(rst), .clear(clear), .count_enable(count_enable),
    .up_down(up_down), .one_shot(one_shot), .load(load), .load_val(load_val),
    .rollover_val(rollover_val), .count_out(count_out),
    .rollover_flag(rollover_flag), .done(done)
  );

  function automatic vec_t mk(logic r, logic c, logic l, logic e, logic u, logic o,
                              logic [3:0] lv, logic [3:0] rv, logic [3:0] ec, logic ef, logic ed);
    vec_t x;
    x.rst = r; x.clr = c; x.ld = l; x.en = e; x.ud = u; x.os = o;
    x.lv = lv; x.rv = rv; x.ec = ec; x.ef = ef; x.ed = ed;
    return x;
  endfunction

  task automatic apply(input vec_t x, input string name);
    @(negedge clk);
    rst = x.rst; clear = x.clr; load = x.ld; count_enable = x.en;
    up_down = x.ud; one_shot = x.os; load_val = x.lv; rollover_val = x.rv;
    @(posedge clk);
    #1;
    tests++;
    if (count_out !== x.ec || rollover_flag !== x.ef || done !== x.ed) begin
      fails++;
      $display("FAIL %s: got count=%0d flag=%0b done=%0b, expected count=%0d flag=%0b done=%0b",
               name, count_out, rollover_flag, done, x.ec, x.ef, x.ed);
    end
  endtask

  initial begin
    rst = 1'b1; clear = 1'b0; load = 1'b0; count_enable = 1'b0;
    up_down = 1'b1; one_shot = 1'b0; load_val = '0; rollover_val = '0;
    //              rst clr ld en ud os lv rv  cnt flag done
    vecs.push_back(mk(1, 0, 0, 1, 1, 0, 0, 5,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 5,  1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 5,  2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 5,  3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 5,  4, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 5,  5, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 5,  1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 5,  2, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 3,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 3,  3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 3,  2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 3,  1, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 3,  3, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 3,  2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 2,  2, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 9,  0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 9,  1, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 9,  2, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 9,  3, 0, 0));
    vecs.push_back(mk(0, 1, 1, 1, 1, 0, 7, 9,  0, 0, 0));
    vecs.push_back(mk(0, 0, 1, 1, 1, 0, 7, 9,  7, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 9,  8, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 9,  9, 1, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 6,  1, 0, 0));
    for (int i = 0; i < 4; i++) vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 0, 1, 0, 0));
    vecs.push_back(mk(0, 0, 1, 0, 1, 0, 12, 5, 12, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 1, 0, 0, 5,  1, 0, 0));
    foreach (vecs[i]) apply(vecs[i], $sformatf("vec%0d", i));

    apply(mk(1, 0, 0, 0, 1, 1, 0, 4, 0, 0, 0), "os_reset");
    for (int i = 1; i <= 8; i++)
      apply(mk(0, 0, 0, 1, 1, 1, 0, 4, (i < 4) ? 4'(i) : 4'd4, i >= 4, i >= 4), $sformatf("os_step%0d", i));
    apply(mk(0, 0, 0, 1, 1, 0, 0, 4, 4, 1, 1), "os_release_ignored");
    apply(mk(0, 0, 1, 1, 1, 1, 2, 4, 2, 0, 0), "os_load_exit");
    apply(mk(0, 0, 0, 1, 1, 1, 0, 4, 3, 0, 0), "os_rerun3");
    apply(mk(0, 0, 0, 1, 1, 1, 0, 4, 4, 1, 1), "os_rehold");
    apply(mk(1, 0, 1, 1, 1, 1, 9, 4, 0, 0, 0), "rst_in_hold");
    apply(mk(0, 0, 0, 1, 1, 0, 0, 4, 1, 0, 0), "resume_after_rst");
    apply(mk(0, 1, 0, 1, 1, 1, 0, 1, 0, 0, 0), "clear_r1");
    apply(mk(0, 0, 0, 1, 0, 1, 0, 1, 1, 1, 1), "down_os_r1");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
